sound_sample_fifo: RTL and testbench

Parametrised successor to the single-byte audio latch in the Plus data controller. Buffers sound samples fetched during video/sound DMA slots (loadSound strobes) in a FIFO and converts them from unsigned to signed. Applies per-pop binary volume scaling and releases samples on an independent sample-rate tick. Adds prefill/underflow management, mute, multi-channel (stereo) support and sticky error flags.

---
 rtl/sound_sample_fifo.sv | 140 ++++++++++++++
 tb/tb_sound_sample_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_sample_fifo.sv
// Audio sample FIFO: buffers offset-binary frames from sound DMA slots, converts them to signed,
// applies binary volume scaling and releases one frame per sample-rate tick with prefill/underflow control.
module sound_sample_fifo #(
   parameter int SAMPLE_W = 8,
   parameter int CHANNELS = 2,
   parameter int VOL_BITS = 3,
   parameter int DEPTH    = 16,
   parameter int PREFILL  = 8,
   localparam int OUT_W   = SAMPLE_W + VOL_BITS,
   localparam int FRAME_W = CHANNELS * SAMPLE_W,
   localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
   input  logic                      clk8,
   input  logic                      _reset,
   input  logic                      loadSound,
   input  logic [FRAME_W-1:0]        sampleData,
   input  logic                      sampleTick,
   input  logic [VOL_BITS-1:0]       vol,
   input  logic                      mute,
   input  logic                      clearFlags,
   output logic [CHANNELS*OUT_W-1:0] audioOut,
   output logic [LEVEL_W-1:0]        level,
   output logic                      playing,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic {FILL, PLAY} state_t;

   state_t                    state;
   state_t                    stateNext;
   logic [FRAME_W-1:0]        sampleRam [DEPTH];
   logic [ADDR_W-1:0]         wrPtr;
   logic [ADDR_W-1:0]         rdPtr;
   logic [FRAME_W-1:0]        signedFrame;
   logic [FRAME_W-1:0]        headFrame;
   logic [CHANNELS*OUT_W-1:0] scaledFrame;
   logic [LEVEL_W-1:0]        levelNext;
   logic                      isFull;
   logic                      isEmpty;
   logic                      doPop;
   logic                      underRun;
   logic                      doPush;
   logic                      dropPush;

   assign isFull    = (level == LEVEL_W'(DEPTH));
   assign isEmpty   = (level == '0);
   assign doPop     = (state == PLAY) && sampleTick && !isEmpty;
   assign underRun  = (state == PLAY) && sampleTick && isEmpty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
   assign doPush    = loadSound && (!isFull || doPop);
   assign dropPush  = loadSound && !doPush;
   assign headFrame = sampleRam[rdPtr];

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         localparam int IN_LSB  = (CHANNELS - 1 - gi) * SAMPLE_W;
         localparam int OUT_LSB = (CHANNELS - 1 - gi) * OUT_W;

         logic [SAMPLE_W-1:0] headSample;
         logic [OUT_W-1:0]    headExt;
         logic [OUT_W-1:0]    product;

         // Flipping the MSB turns offset-binary into two's complement.
         assign signedFrame[IN_LSB +: SAMPLE_W] =
            sampleData[IN_LSB +: SAMPLE_W] ^ (SAMPLE_W'(1) << (SAMPLE_W - 1));

         assign headSample = headFrame[IN_LSB +: SAMPLE_W];
         assign headExt    = {{VOL_BITS{headSample[SAMPLE_W-1]}}, headSample};

         always_comb begin
            product = '0;
            for (int b = 0; b < VOL_BITS; b++) begin
               if (vol[b]) begin
                  product = product + (headExt << b);
               end
            end
         end

         assign scaledFrame[OUT_LSB +: OUT_W] = product;
      end
   endgenerate

   always_comb begin
      levelNext = level;
      if (doPush && !doPop) begin
         levelNext = level + 1'b1;
      end else if (doPop && !doPush) begin
         levelNext = level - 1'b1;
      end
   end

   always_comb begin
      stateNext = state;
      if (state == FILL) begin
         if (levelNext >= LEVEL_W'(PREFILL)) begin
            stateNext = PLAY;
         end
      end else if (underRun) begin
         stateNext = FILL;
      end
   end

   // Sample storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk8) begin
      if (doPush) begin
         sampleRam[wrPtr] <= signedFrame;
      end
   end

   always_ff @(posedge clk8 or negedge _reset) begin
      if (!_reset) begin
         state     <= FILL;
         wrPtr     <= '0;
         rdPtr     <= '0;
         level     <= '0;
         audioOut  <= '0;
         playing   <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= stateNext;
         playing   <= (stateNext == PLAY);
         level     <= levelNext;
         overflow  <= (overflow & ~clearFlags) | dropPush;
         underflow <= (underflow & ~clearFlags) | underRun;
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr    <= rdPtr + 1'b1;
            audioOut <= mute ? '0 : scaledFrame;
         end
      end
   end

endmodule

// File: tb/tb_sound_sample_fifo.sv
// Scoreboard bench for sound_sample_fifo: a queue-based reference model predicts every cycle's
// outputs; a monitor pops and compares them one clock edge later.
`timescale 1ns/1ps
module tb_sound_sample_fifo;

   localparam int SAMPLE_W = 8;
   localparam int CHANNELS = 2;
   localparam int VOL_BITS = 3;
   localparam int DEPTH    = 16;
   localparam int PREFILL  = 8;
   localparam int OUT_W    = SAMPLE_W + VOL_BITS;
   localparam int FRAME_W  = CHANNELS * SAMPLE_W;
   localparam int AUD_W    = CHANNELS * OUT_W;
   localparam int LEVEL_W  = $clog2(DEPTH) + 1;

   logic                clk8 = 1'b0;
   logic                _reset;
   logic                loadSound;
   logic [FRAME_W-1:0]  sampleData;
   logic                sampleTick;
   logic [VOL_BITS-1:0] vol;
   logic                mute;
   logic                clearFlags;
   logic [AUD_W-1:0]    audioOut;
   logic [LEVEL_W-1:0]  level;
   logic                playing;
   logic                overflow;
   logic                underflow;

   sound_sample_fifo #(
      .SAMPLE_W(SAMPLE_W), .CHANNELS(CHANNELS), .VOL_BITS(VOL_BITS),
      .DEPTH(DEPTH), .PREFILL(PREFILL)
   ) dut (
      .clk8(clk8), ._reset(_reset), .loadSound(loadSound), .sampleData(sampleData),
      .sampleTick(sampleTick), .vol(vol), .mute(mute), .clearFlags(clearFlags),
      .audioOut(audioOut), .level(level), .playing(playing),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk8 = ~clk8;

   typedef struct {
      logic [AUD_W-1:0] aud;
      int               lvl;
      bit               play;
      bit               ovf;
      bit               unf;
      bit               tick;
   } exp_t;

   exp_t               expQ[$];
   logic [FRAME_W-1:0] modelQ[$];
   bit                 mPlay;
   bit                 mOvf;
   bit                 mUnf;
   logic [AUD_W-1:0]   mAud;
   int                 checks = 0;
   int                 errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: signed sample = raw - 2^(SAMPLE_W-1), product = sample * vol.
   function automatic logic [AUD_W-1:0] scaleFrame(input logic [FRAME_W-1:0] raw, input int v);
      logic [AUD_W-1:0] r;
      int s;
      int p;
      logic [OUT_W-1:0] pw;
      r = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         s  = int'(raw[(CHANNELS-1-ch)*SAMPLE_W +: SAMPLE_W]) - (1 << (SAMPLE_W - 1));
         p  = s * v;
         pw = p[OUT_W-1:0];
         r[(CHANNELS-1-ch)*OUT_W +: OUT_W] = pw;
      end
      return r;
   endfunction

   task automatic modelReset();
      modelQ.delete();
      expQ.delete();
      mPlay = 0;
      mOvf  = 0;
      mUnf  = 0;
      mAud  = '0;
   endtask

   // Apply one cycle of stimulus (called at posedge+2), update the model, queue the expectation.
   task automatic cycle(input bit ld, input logic [FRAME_W-1:0] d, input bit tk,
                        input int v, input bit m, input bit clr);
      bit   pop;
      bit   under;
      bit   push;
      exp_t e;
      logic [FRAME_W-1:0] head;
      loadSound  = ld;
      sampleData = d;
      sampleTick = tk;
      vol        = v[VOL_BITS-1:0];
      mute       = m;
      clearFlags = clr;
      pop   = mPlay && tk && (modelQ.size() > 0);
      under = mPlay && tk && (modelQ.size() == 0);
      push  = ld && ((modelQ.size() < DEPTH) || pop);
      if (pop) begin
         head = modelQ.pop_front();
         mAud = m ? '0 : scaleFrame(head, v);
      end
      if (push) modelQ.push_back(d);
      mOvf = (mOvf && !clr) || (ld && !push);
      mUnf = (mUnf && !clr) || under;
      if (!mPlay) mPlay = (modelQ.size() >= PREFILL);
      else if (under) mPlay = 0;
      e.aud = mAud; e.lvl = modelQ.size(); e.play = mPlay;
      e.ovf = mOvf; e.unf = mUnf; e.tick = tk;
      expQ.push_back(e);
      @(posedge clk8);
      #2;
   endtask

   task automatic pushFrame(input logic [FRAME_W-1:0] d);
      cycle(1, d, 0, 0, 0, 0);
   endtask

   task automatic tickOnce(input int v, input bit m);
      cycle(0, '0, 1, v, m, 0);
   endtask

   task automatic doReset();
      _reset = 1'b0;
      modelReset();
      #1;
      chk("rst_audioOut", 64'(audioOut), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_playing", 64'(playing), 64'd0);
      chk("rst_flags", 64'({overflow, underflow}), 64'd0);
      loadSound = 0; sampleTick = 0; clearFlags = 0; mute = 0;
      @(posedge clk8);
      @(posedge clk8);
      #2;
      _reset = 1'b1;
   endtask

   // Monitor: one expected record per clock edge, sampled 1 ns after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk8);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("audioOut", 64'(audioOut), 64'(e.aud));
            chk("level", 64'(level), 64'(e.lvl));
            chk("playing", 64'(playing), 64'(e.play));
            chk("overflow", 64'(overflow), 64'(e.ovf));
            chk("underflow", 64'(underflow), 64'(e.unf));
            if (e.tick)
               $display("tick t=%0t audioOut=%h level=%0d playing=%0b ovf=%0b unf=%0b",
                        $time, audioOut, level, playing, overflow, underflow);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AUD_W-1:0] expAud;
      _reset = 1'b0; loadSound = 0; sampleData = '0; sampleTick = 0;
      vol = '0; mute = 0; clearFlags = 0;
      modelReset();
      @(posedge clk8);
      #2;
      doReset();

      // Reset mid-stream with level=5 while playing, then prefill boundary.
      for (int i = 0; i < 8; i++) pushFrame(FRAME_W'($urandom));
      for (int i = 0; i < 3; i++) tickOnce(5, 0);
      chk("mid_level5", 64'(level), 64'd5);
      doReset();
      for (int i = 0; i < 7; i++) pushFrame(FRAME_W'($urandom));
      chk("prefill7_idle", 64'(playing), 64'd0);
      pushFrame(FRAME_W'($urandom));
      chk("prefill8_play", 64'(playing), 64'd1);

      // Known scaling values.
      doReset();
      pushFrame(16'hFF00);
      pushFrame(16'h8080);
      for (int i = 0; i < 6; i++) pushFrame(FRAME_W'($urandom));
      tickOnce(7, 0);
      expAud = {11'h379, 11'h480};
      chk("scale_ff00_vol7", 64'(audioOut), 64'(expAud));
      tickOnce(1, 0);
      chk("scale_8080_vol1", 64'(audioOut), 64'd0);

      // Overflow and clearFlags.
      doReset();
      for (int i = 0; i < 17; i++) pushFrame(FRAME_W'($urandom));
      chk("ovf_level16", 64'(level), 64'd16);
      chk("ovf_set", 64'(overflow), 64'd1);
      cycle(0, '0, 0, 0, 0, 1);
      chk("ovf_cleared", 64'(overflow), 64'd0);
      for (int i = 0; i < 17; i++) tickOnce(int'($urandom_range(0, 7)), 0);

      // Underflow after prefill drained; further ticks hold state.
      doReset();
      for (int i = 0; i < 8; i++) pushFrame(FRAME_W'($urandom));
      for (int i = 0; i < 12; i++) tickOnce(int'($urandom_range(1, 7)), 0);

      // Mute drains without output.
      doReset();
      for (int i = 0; i < 10; i++) pushFrame(FRAME_W'($urandom));
      tickOnce(7, 1);
      chk("mute_level9", 64'(level), 64'd9);
      chk("mute_zero", 64'(audioOut), 64'd0);
      tickOnce(7, 0);

      // Simultaneous push and pop at full.
      doReset();
      for (int i = 0; i < 16; i++) pushFrame(FRAME_W'($urandom));
      cycle(1, 16'hC3A5, 1, 3, 0, 0);
      chk("full_pushpop_level", 64'(level), 64'd16);
      chk("full_pushpop_ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 17; i++) tickOnce(4, 0);

      // Randomised traffic with occasional resets.
      doReset();
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 199) == 0) doReset();
         else cycle($urandom_range(0, 99) < 40, FRAME_W'($urandom),
                    $urandom_range(0, 99) < 35, int'($urandom_range(0, 7)),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      end
      cycle(0, '0, 0, 0, 0, 0);

      repeat (3) @(posedge clk8);
      #2;
      chk("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
